video_wb_arbiter: RTL and testbench

//  Two-requester Wishbone master arbiter sharing the single system-bus master port.

---
 rtl/video_wb_arbiter.sv | 117 +++++++++++
 tb/tb_video_wb_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_wb_arbiter.sv
// Two-requester Wishbone master arbiter. The registered owner drives the bus
// through a combinational mux, and the owner can be preempted after MAX_BURST beats.
module video_wb_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_cyc,
    input  logic [1:0]      req_stb,
    input  logic [1:0]      req_lock,
    input  logic [1:0]      req_we,
    input  logic [7:0]      req_sel,
    input  logic [2*AW-1:0] req_adr,
    input  logic [2*DW-1:0] req_dat_w,
    output logic [1:0]      req_ack,
    output logic [1:0]      req_err,
    output logic [DW-1:0]   req_dat_r,
    output logic [1:0]      grant,
    output logic            p_wb_CYC_O,
    output logic            p_wb_STB_O,
    output logic            p_wb_LOCK_O,
    output logic            p_wb_WE_O,
    output logic [3:0]      p_wb_SEL_O,
    output logic [AW-1:0]   p_wb_ADR_O,
    output logic [DW-1:0]   p_wb_DAT_O,
    input  logic            p_wb_ACK_I,
    input  logic            p_wb_ERR_I,
    input  logic [DW-1:0]   p_wb_DAT_I
);
    localparam int            BW         = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BW-1:0] BEAT_LAST  = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;
    localparam logic          PREEMPT_EN = (MAX_BURST != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          owned;
    logic          own;
    logic          term;

    assign owned = (state_q != IDLE);
    assign own   = (state_q == GNT1);
    assign grant = {state_q == GNT1, state_q == GNT0};

    // A beat is one STB/ACK (or STB/ERR) handshake: the owner holds STB and its
    // request fields stable until the slave terminates the beat with ACK or ERR.
    assign term = p_wb_ACK_I | p_wb_ERR_I;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (req_cyc == 2'b11) state_d = last_q ? GNT0 : GNT1;
                else if (req_cyc[0])  state_d = GNT0;
                else if (req_cyc[1])  state_d = GNT1;
            end
            GNT0, GNT1: begin
                // Releasing the bus takes priority over a preemption on the same edge.
                if (!req_cyc[own]) begin
                    state_d = IDLE;
                    last_d  = own;
                    beat_d  = '0;
                end else if (PREEMPT_EN && term && beat_q == BEAT_LAST &&
                             !req_lock[own] && req_cyc[~own]) begin
                    state_d = own ? GNT0 : GNT1;
                    last_d  = own;
                    beat_d  = '0;
                end else if (term && beat_q != BEAT_LAST) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p_wb_CYC_O  = owned & req_cyc[own];
        p_wb_STB_O  = owned & req_stb[own];
        p_wb_LOCK_O = owned & req_lock[own];
        p_wb_WE_O   = owned & req_we[own];
        p_wb_SEL_O  = '0;
        p_wb_ADR_O  = '0;
        p_wb_DAT_O  = '0;
        if (owned) begin
            p_wb_SEL_O = own ? req_sel[7:4]          : req_sel[3:0];
            p_wb_ADR_O = own ? req_adr[2*AW-1:AW]    : req_adr[AW-1:0];
            p_wb_DAT_O = own ? req_dat_w[2*DW-1:DW]  : req_dat_w[DW-1:0];
        end
    end

    assign req_ack   = grant & {2{p_wb_ACK_I}};
    assign req_err   = grant & {2{p_wb_ERR_I}};
    assign req_dat_r = p_wb_DAT_I;

endmodule

// File: tb/tb_video_wb_arbiter.sv
// Bench for video_wb_arbiter: two requester drivers, a one-cycle-ACK slave and
// per-requester expected queues checked against what each requester received.
module tb_video_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_cyc, req_stb, req_lock, req_we;
    logic [7:0]  req_sel;
    logic [63:0] req_adr, req_dat_w;
    logic [1:0]  req_ack, req_err;
    logic [31:0] req_dat_r;
    logic [1:0]  grant;
    logic        p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O;
    logic [3:0]  p_wb_SEL_O;
    logic [31:0] p_wb_ADR_O, p_wb_DAT_O;
    logic        p_wb_ACK_I, p_wb_ERR_I;
    logic [31:0] p_wb_DAT_I;

    int vectors;
    int miscompares;

    logic [32:0] exp_q0[$], exp_q1[$];
    logic [32:0] got_q0[$], got_q1[$];
    int          ack_log[$];
    int          exp_log[$];
    logic [31:0] err_adr, dead_adr;
    int          ack_cnt0, ack_cnt1;

    video_wb_arbiter #(.MAX_BURST(8), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req_cyc(req_cyc), .req_stb(req_stb), .req_lock(req_lock), .req_we(req_we),
        .req_sel(req_sel), .req_adr(req_adr), .req_dat_w(req_dat_w),
        .req_ack(req_ack), .req_err(req_err), .req_dat_r(req_dat_r), .grant(grant),
        .p_wb_CYC_O(p_wb_CYC_O), .p_wb_STB_O(p_wb_STB_O), .p_wb_LOCK_O(p_wb_LOCK_O),
        .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O), .p_wb_ADR_O(p_wb_ADR_O),
        .p_wb_DAT_O(p_wb_DAT_O), .p_wb_ACK_I(p_wb_ACK_I), .p_wb_ERR_I(p_wb_ERR_I),
        .p_wb_DAT_I(p_wb_DAT_I)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Free-running ACK counters; tests take deltas.
    initial begin
        ack_cnt0 = 0;
        ack_cnt1 = 0;
        forever begin
            @(negedge clk);
            if (req_ack[0]) ack_cnt0 = ack_cnt0 + 1;
            if (req_ack[1]) ack_cnt1 = ack_cnt1 + 1;
        end
    end

    // Slave: samples the bus mid-cycle, answers one cycle after STB.
    initial begin : slave
        logic        acc;
        logic [31:0] s_adr, s_dat;
        logic [3:0]  s_sel;
        logic        s_we;
        p_wb_ACK_I = 1'b0;
        p_wb_ERR_I = 1'b0;
        p_wb_DAT_I = 32'h0;
        forever begin
            @(negedge clk);
            acc   = !reset && p_wb_CYC_O && p_wb_STB_O && !p_wb_ACK_I && !p_wb_ERR_I;
            s_adr = p_wb_ADR_O;
            s_dat = p_wb_DAT_O;
            s_sel = p_wb_SEL_O;
            s_we  = p_wb_WE_O;
            @(posedge clk);
            #1;
            p_wb_ACK_I = acc && (s_adr != err_adr);
            p_wb_ERR_I = acc && (s_adr == err_adr);
            if (acc)
                p_wb_DAT_I = (!s_we && s_adr == dead_adr) ? 32'hDEADBEEF
                           : (s_adr ^ s_dat ^ {s_sel, 28'h0} ^ {31'h0, s_we});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset;
        reset     = 1'b1;
        req_cyc   = 2'b00;
        req_stb   = 2'b00;
        req_lock  = 2'b00;
        req_we    = 2'b00;
        req_sel   = 8'h00;
        req_adr   = 64'h0;
        req_dat_w = 64'h0;
        err_adr   = 32'hFFFF_FFF0;
        dead_adr  = 32'hFFFF_FFF0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q0.delete(); exp_q1.delete();
        got_q0.delete(); got_q1.delete();
        ack_log.delete(); exp_log.delete();
    endtask

    // Requester i issues n beats at base+4k; we_mask bit k selects write.
    task automatic master(input int i, input int n, input logic [31:0] base,
                          input logic lk, input logic [31:0] we_mask);
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic        we;
        logic [32:0] e;
        logic        done;
        int          guard;
        for (int k = 0; k < n; k++) begin
            adr = base + 32'(4 * k);
            dat = {8'(i), 8'(k), 16'hA5C3};
            sel = 4'hF ^ 4'(k);
            we  = we_mask[k];
            req_adr[i*32 +: 32]   = adr;
            req_dat_w[i*32 +: 32] = dat;
            req_sel[i*4 +: 4]     = sel;
            req_we[i]   = we;
            req_lock[i] = lk;
            req_cyc[i]  = 1'b1;
            req_stb[i]  = 1'b1;
            e[32]   = (adr == err_adr);
            e[31:0] = (!we && adr == dead_adr) ? 32'hDEADBEEF
                    : (adr ^ dat ^ {sel, 28'h0} ^ {31'h0, we});
            if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            done  = 1'b0;
            guard = 0;
            while (!done && !reset && guard < 200) begin
                @(negedge clk);
                guard++;
                if (!reset && (req_ack[i] || req_err[i])) begin
                    if (i == 0) got_q0.push_back({req_err[i], req_dat_r});
                    else        got_q1.push_back({req_err[i], req_dat_r});
                    ack_log.push_back(i);
                    done = 1'b1;
                end
            end
            if (!done) break;
            @(posedge clk);
            #1;
        end
        req_cyc[i]  = 1'b0;
        req_stb[i]  = 1'b0;
        req_lock[i] = 1'b0;
    endtask

    task automatic push_log(input int id, input int cnt);
        for (int k = 0; k < cnt; k++) exp_log.push_back(id);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset     = 1'b1;
        req_cyc   = 2'b11;
        req_stb   = 2'b11;
        req_lock  = 2'b11;
        req_we    = 2'b11;
        req_sel   = 8'hFF;
        req_adr   = {64{1'b1}};
        req_dat_w = {64{1'b1}};
        repeat (2) @(posedge clk);
        #3;
        vectors++;
        if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b expected 00", grant); end
        vectors++;
        if ({p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_ctrl: got %b expected 0000", {p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O});
        end
        vectors++;
        if ({p_wb_SEL_O, p_wb_ADR_O, p_wb_DAT_O} !== 68'h0) begin
            miscompares++;
            $display("FAIL rst_fields: got %h/%h/%h expected 0", p_wb_SEL_O, p_wb_ADR_O, p_wb_DAT_O);
        end
        vectors++;
        if ({req_ack, req_err} !== 4'b0000) begin
            miscompares++; $display("FAIL rst_ackerr: got %b expected 0000", {req_ack, req_err});
        end
        do_reset;
        @(negedge clk);
        vectors++;
        if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_idle_grant: got %b expected 00", grant); end
    endtask

    task automatic test_single_requester;
        logic [32:0] e, g;
        int c0, c1;
        do_reset;
        c0 = ack_cnt0;
        c1 = ack_cnt1;
        fork
            master(0, 4, 32'h100, 1'b0, 32'hFFFF_FFFF);
            begin
                @(negedge clk);
                vectors++;
                if (grant !== 2'b00) begin miscompares++; $display("FAIL t1_grant_before: got %b expected 00", grant); end
                @(negedge clk);
                vectors++;
                if (grant !== 2'b01) begin miscompares++; $display("FAIL t1_grant_latency: got %b expected 01", grant); end
            end
        join
        @(posedge clk);
        #1;
        vectors++;
        if (grant !== 2'b00 || p_wb_CYC_O !== 1'b0) begin
            miscompares++; $display("FAIL t1_idle_after_drop: got grant %b cyc %b expected 00 0", grant, p_wb_CYC_O);
        end
        vectors++;
        if (ack_cnt0 - c0 != 4) begin miscompares++; $display("FAIL t1_ack0_count: got %0d expected 4", ack_cnt0 - c0); end
        vectors++;
        if (ack_cnt1 - c1 != 0) begin miscompares++; $display("FAIL t1_ack1_count: got %0d expected 0", ack_cnt1 - c1); end
        while (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            g = (got_q0.size() > 0) ? got_q0.pop_front() : 'x;
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL t1_sb0: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_tie_after_reset;
        logic [1:0] hist[$];
        int last01, first10;
        do_reset;
        fork
            master(0, 2, 32'h200, 1'b0, 32'hFFFF_FFFF);
            master(1, 2, 32'h300, 1'b0, 32'h0);
            repeat (24) begin
                @(negedge clk);
                hist.push_back(grant);
            end
        join
        last01  = -1;
        first10 = -1;
        foreach (hist[k]) begin
            if (hist[k] == 2'b01) last01 = k;
            if (hist[k] == 2'b10 && first10 < 0) first10 = k;
        end
        vectors++;
        if (last01 < 0 || first10 - last01 != 2) begin
            miscompares++; $display("FAIL t2_idle_gap: got last01 %0d first10 %0d expected gap 2", last01, first10);
        end
        push_log(0, 2);
        push_log(1, 2);
        vectors++;
        if (ack_log.size() != exp_log.size()) begin
            miscompares++; $display("FAIL t2_log_len: got %0d expected %0d", ack_log.size(), exp_log.size());
        end
        for (int k = 0; k < ack_log.size() && k < exp_log.size(); k++) begin
            vectors++;
            if (ack_log[k] != exp_log[k]) begin miscompares++; $display("FAIL t2_order[%0d]: got %0d expected %0d", k, ack_log[k], exp_log[k]); end
        end
    endtask

    task automatic test_preempt(input logic lk);
        logic [32:0] e, g;
        do_reset;
        fork
            master(0, 20, 32'h1000, lk, 32'hFFFF_FFFF);
            begin
                repeat (3) @(posedge clk);
                #1;
                master(1, 8, 32'h2000, 1'b0, 32'h0);
            end
        join
        if (lk) begin
            push_log(0, 20);
            push_log(1, 8);
        end else begin
            push_log(0, 8);
            push_log(1, 8);
            push_log(0, 12);
        end
        vectors++;
        if (ack_log.size() != exp_log.size()) begin
            miscompares++; $display("FAIL preempt_log_len(lock=%0b): got %0d expected %0d", lk, ack_log.size(), exp_log.size());
        end
        for (int k = 0; k < ack_log.size() && k < exp_log.size(); k++) begin
            vectors++;
            if (ack_log[k] != exp_log[k]) begin
                miscompares++; $display("FAIL preempt_order(lock=%0b)[%0d]: got %0d expected %0d", lk, k, ack_log[k], exp_log[k]);
            end
        end
        while (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            g = (got_q0.size() > 0) ? got_q0.pop_front() : 'x;
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL preempt_sb0(lock=%0b): got %h expected %h", lk, g, e); end
        end
        while (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            g = (got_q1.size() > 0) ? got_q1.pop_front() : 'x;
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL preempt_sb1(lock=%0b): got %h expected %h", lk, g, e); end
        end
        vectors++;
        if (got_q0.size() + got_q1.size() != 0) begin
            miscompares++; $display("FAIL preempt_extra_acks: got %0d expected 0", got_q0.size() + got_q1.size());
        end
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        master(0, 1, 32'h400, 1'b0, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        fork
            master(0, 10, 32'h500, 1'b0, 32'hFFFF_FFFF);
            begin
                repeat (5) @(posedge clk);
                #2;
                reset = 1'b1;
                #1;
                vectors++;
                if ({p_wb_CYC_O, p_wb_STB_O} !== 2'b00) begin
                    miscompares++; $display("FAIL t5_cyc_stb_async: got %b expected 00", {p_wb_CYC_O, p_wb_STB_O});
                end
                vectors++;
                if (grant !== 2'b00 || req_ack !== 2'b00) begin
                    miscompares++; $display("FAIL t5_grant_async: got grant %b ack %b expected 00 00", grant, req_ack);
                end
                do_reset;
            end
        join
        fork
            master(0, 2, 32'h600, 1'b0, 32'hFFFF_FFFF);
            master(1, 2, 32'h700, 1'b0, 32'hFFFF_FFFF);
        join
        push_log(0, 2);
        push_log(1, 2);
        vectors++;
        if (ack_log.size() != exp_log.size()) begin
            miscompares++; $display("FAIL t5_log_len: got %0d expected %0d", ack_log.size(), exp_log.size());
        end
        for (int k = 0; k < ack_log.size() && k < exp_log.size(); k++) begin
            vectors++;
            if (ack_log[k] != exp_log[k]) begin miscompares++; $display("FAIL t5_order[%0d]: got %0d expected %0d", k, ack_log[k], exp_log[k]); end
        end
    endtask

    task automatic test_err_and_read;
        logic [32:0] e, g;
        do_reset;
        err_adr  = 32'h3008;
        dead_adr = 32'h300C;
        fork
            master(1, 10, 32'h3000, 1'b0, ~32'h8);
            begin
                repeat (3) @(posedge clk);
                #1;
                master(0, 2, 32'h4000, 1'b0, 32'hFFFF_FFFF);
            end
        join
        push_log(1, 8);
        push_log(0, 2);
        push_log(1, 2);
        vectors++;
        if (ack_log.size() != exp_log.size()) begin
            miscompares++; $display("FAIL t6_log_len: got %0d expected %0d", ack_log.size(), exp_log.size());
        end
        for (int k = 0; k < ack_log.size() && k < exp_log.size(); k++) begin
            vectors++;
            if (ack_log[k] != exp_log[k]) begin miscompares++; $display("FAIL t6_order[%0d]: got %0d expected %0d", k, ack_log[k], exp_log[k]); end
        end
        while (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            g = (got_q1.size() > 0) ? got_q1.pop_front() : 'x;
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL t6_sb1: got %h expected %h", g, e); end
        end
        while (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            g = (got_q0.size() > 0) ? got_q0.pop_front() : 'x;
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL t6_sb0: got %h expected %h", g, e); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        err_adr     = 32'hFFFF_FFF0;
        dead_adr    = 32'hFFFF_FFF0;
        test_reset;
        test_single_requester;
        test_tie_after_reset;
        test_preempt(1'b0);
        test_preempt(1'b1);
        test_reset_mid_burst;
        test_err_and_read;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
